// File: rtl/apb_mem_slave_p_if.sv
// APB bus bundle between a master and apb_mem_slave_p; widths follow the slave parameters.
interface apb_mem_slave_p_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int SEL_W  = 2,
  parameter int WAIT_W = 8
);
  logic [SEL_W-1:0]  sel;
  logic              enable;
  logic              write;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [WAIT_W-1:0] wait_cycles;
  logic              ready;
  logic [DATA_W-1:0] rdata;
  logic              slverr;

  modport master (
    output sel, enable, write, addr, wdata, wait_cycles,
    input  ready, rdata, slverr
  );

  modport slave (
    input  sel, enable, write, addr, wdata, wait_cycles,
    output ready, rdata, slverr
  );
endinterface

// File: rtl/apb_mem_slave_p.sv
// APB slave in front of a synchronous single-port memory, with programmable wait states,
// out-of-range slverr and abort handling.
//   state  | meaning
//   IDLE   | waiting for a setup cycle (sel==ID, enable==0); read strobe issued here
//   ACCESS | counting wait states; completes when cnt==0 with enable and sel held
module apb_mem_slave_p #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int SEL_W  = 2,
  parameter int ID     = 1,
  parameter int DEPTH  = 256,
  parameter int WAIT_W = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  apb_mem_slave_p_if.slave         bus,
  output logic                     mem_wren,
  output logic                     mem_rden,
  output logic [$clog2(DEPTH)-1:0] mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata
);
  localparam int MAW = $clog2(DEPTH);
  localparam logic [ADDR_W:0]  DEPTH_A = (ADDR_W+1)'(DEPTH);
  localparam logic [SEL_W-1:0] ID_S    = SEL_W'(ID);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] cnt;
  logic [MAW-1:0]    addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              write_q;
  logic              err_q;
  logic              first_q;
  logic              selected;
  logic              setup;
  logic              addr_err;
  logic              ready;

  assign selected = (bus.sel == ID_S);
  assign setup    = (state == IDLE) && selected && !bus.enable;
  assign addr_err = ({1'b0, bus.addr} >= DEPTH_A);
  assign ready    = (state == ACCESS) && (cnt == '0) && bus.enable && selected;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mem_rden  = 1'b0;
    mem_addr  = addr_q;
    case (state)
      IDLE: begin
        mem_addr = bus.addr[MAW-1:0];
        if (setup) begin
          state_nxt = ACCESS;
          mem_rden  = !bus.write && !addr_err;
        end
      end
      ACCESS: begin
        // completion and abort both return to IDLE
        if (!selected || !bus.enable || cnt == '0) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      first_q <= 1'b0;
    end else if (setup) begin
      cnt     <= bus.wait_cycles;
      addr_q  <= bus.addr[MAW-1:0];
      wdata_q <= bus.wdata;
      write_q <= bus.write;
      err_q   <= addr_err;
      first_q <= 1'b1;
    end else if (state == ACCESS) begin
      first_q <= 1'b0;
      // memory data is only valid in the first ACCESS cycle, so hold it for later completions
      if (first_q) rdata_q <= mem_rdata;
      if (bus.enable && cnt != '0) cnt <= cnt - WAIT_W'(1);
    end
  end

  assign mem_wren   = ready && write_q && !err_q;
  assign mem_wdata  = wdata_q;
  assign bus.ready  = ready;
  assign bus.slverr = ready && err_q;
  assign bus.rdata  = (ready && !err_q) ? (first_q ? mem_rdata : rdata_q) : '0;
endmodule

// File: tb/tb_apb_mem_slave_p.sv
// Bench for apb_mem_slave_p (DATA_W=16, DEPTH=128): vector table driven through APB,
// responses checked against a scoreboard queue.
module tb_apb_mem_slave_p;
  localparam int DW = 16;
  localparam int AW = 8;
  localparam int SW = 2;
  localparam int WW = 8;
  localparam int DEPTH = 128;

  typedef struct {
    logic [SW-1:0] sel;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [WW-1:0] w;
    int            abort_after;
    logic          abort_sel;
    logic          exp_resp;
    logic          exp_rden;
    logic          exp_err;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  typedef struct packed {
    logic          err;
    logic [DW-1:0] rdata;
  } resp_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          mem_wren;
  logic          mem_rden;
  logic [6:0]    mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] mem [0:DEPTH-1];

  int    checks;
  int    errors;
  resp_t sb_q[$];
  vec_t  vecs[19];

  apb_mem_slave_p_if #(.DATA_W(DW), .ADDR_W(AW), .SEL_W(SW), .WAIT_W(WW)) bus_if ();

  apb_mem_slave_p #(
    .DATA_W(DW), .ADDR_W(AW), .SEL_W(SW), .ID(1), .DEPTH(DEPTH), .WAIT_W(WW)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus_if),
    .mem_wren  (mem_wren),
    .mem_rden  (mem_rden),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_wren) mem[mem_addr] = mem_wdata;
    if (mem_rden) mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n === 1'b1) chk("strobe_exclusive", 32'(mem_rden & mem_wren), 32'd0);
  end

  function automatic vec_t mk(input logic [SW-1:0] sel, input logic wr, input logic [AW-1:0] addr,
                              input logic [DW-1:0] wdata, input logic [WW-1:0] w,
                              input int abort_after, input logic abort_sel, input logic exp_resp,
                              input logic exp_rden, input logic exp_err, input logic [DW-1:0] exp_rdata);
    vec_t v;
    v.sel = sel; v.wr = wr; v.addr = addr; v.wdata = wdata; v.w = w;
    v.abort_after = abort_after; v.abort_sel = abort_sel; v.exp_resp = exp_resp;
    v.exp_rden = exp_rden; v.exp_err = exp_err; v.exp_rdata = exp_rdata;
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    int    ncyc;
    logic  exp_ready;
    logic  aborting;
    resp_t r;
    bus_if.sel         = v.sel;
    bus_if.enable      = 1'b0;
    bus_if.write       = v.wr;
    bus_if.addr        = v.addr;
    bus_if.wdata       = v.wdata;
    bus_if.wait_cycles = v.w;
    if (v.exp_resp) sb_q.push_back(resp_t'{v.exp_err, v.exp_rdata});
    @(negedge clk);
    chk("setup_ready", 32'(bus_if.ready), 32'd0);
    chk("setup_rden", 32'(mem_rden), 32'(v.exp_rden));
    if (v.exp_rden) chk("setup_mem_addr", 32'(mem_addr), 32'(v.addr[6:0]));
    @(posedge clk); #1;
    // scramble the bus after setup so only latched values can produce the right result
    bus_if.enable      = 1'b1;
    bus_if.addr        = ~v.addr;
    bus_if.wdata       = ~v.wdata;
    bus_if.wait_cycles = '0;
    ncyc = int'(v.w) + 1;
    for (int k = 1; k <= ncyc; k++) begin
      aborting = (v.abort_after >= 0) && (k > v.abort_after);
      if (aborting) begin
        if (v.abort_sel) bus_if.sel = '0;
        else             bus_if.enable = 1'b0;
      end
      exp_ready = v.exp_resp && (k == ncyc);
      @(negedge clk);
      chk("ready", 32'(bus_if.ready), 32'(exp_ready));
      chk("access_rden", 32'(mem_rden), 32'd0);
      chk("mem_wren", 32'(mem_wren), 32'(exp_ready && v.wr && !v.exp_err));
      if (mem_wren) begin
        chk("wr_mem_addr", 32'(mem_addr), 32'(v.addr[6:0]));
        chk("wr_mem_wdata", 32'(mem_wdata), 32'(v.wdata));
      end
      if (bus_if.ready === 1'b1) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ready: got ready=1 required no response at %0t", $time);
        end else begin
          r = sb_q.pop_front();
          chk("slverr", 32'(bus_if.slverr), 32'(r.err));
          if (!v.wr) chk("rdata", 32'(bus_if.rdata), 32'(r.rdata));
        end
      end else begin
        chk("wait_rdata", 32'(bus_if.rdata), 32'd0);
        chk("wait_slverr", 32'(bus_if.slverr), 32'd0);
      end
      @(posedge clk); #1;
      if (aborting) break;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;
    reset_n = 1'b0;
    bus_if.sel = '0; bus_if.enable = 1'b0; bus_if.write = 1'b0;
    bus_if.addr = '0; bus_if.wdata = '0; bus_if.wait_cycles = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    mem[8'h00] = 16'h0F0F;
    mem[8'h20] = 16'h7777;
    mem[8'h30] = 16'h3030;

    //          sel   wr    addr   wdata     w       ab  asel resp rden err  rdata
    vecs[0]  = mk(2'd1, 1'b0, 8'h30, 16'h0000, 8'd0,   -1, 0, 1, 1, 0, 16'h3030);
    vecs[1]  = mk(2'd1, 1'b1, 8'h10, 16'h00A5, 8'd0,   -1, 0, 1, 0, 0, 16'h0000);
    vecs[2]  = mk(2'd1, 1'b0, 8'h10, 16'h0000, 8'd3,   -1, 0, 1, 1, 0, 16'h00A5);
    vecs[3]  = mk(2'd1, 1'b0, 8'h90, 16'h0000, 8'd1,   -1, 0, 1, 0, 1, 16'h0000);
    vecs[4]  = mk(2'd2, 1'b1, 8'h20, 16'h1234, 8'd0,   -1, 0, 0, 0, 0, 16'h0000);
    vecs[5]  = mk(2'd1, 1'b1, 8'h20, 16'h5555, 8'd4,    2, 0, 0, 0, 0, 16'h0000);
    vecs[6]  = mk(2'd1, 1'b0, 8'h20, 16'h0000, 8'd0,   -1, 0, 1, 1, 0, 16'h7777);
    vecs[7]  = mk(2'd1, 1'b1, 8'h05, 16'hBEEF, 8'd0,   -1, 0, 1, 0, 0, 16'h0000);
    vecs[8]  = mk(2'd1, 1'b0, 8'h05, 16'h0000, 8'd0,   -1, 0, 1, 1, 0, 16'hBEEF);
    vecs[9]  = mk(2'd1, 1'b0, 8'h05, 16'h0000, 8'd2,   -1, 0, 1, 1, 0, 16'hBEEF);
    vecs[10] = mk(2'd1, 1'b1, 8'h7F, 16'hCAFE, 8'd1,   -1, 0, 1, 0, 0, 16'h0000);
    vecs[11] = mk(2'd1, 1'b0, 8'h7F, 16'h0000, 8'd0,   -1, 0, 1, 1, 0, 16'hCAFE);
    vecs[12] = mk(2'd1, 1'b1, 8'h80, 16'h1111, 8'd2,   -1, 0, 1, 0, 1, 16'h0000);
    vecs[13] = mk(2'd1, 1'b0, 8'h00, 16'h0000, 8'd255, -1, 0, 1, 1, 0, 16'h0F0F);
    vecs[14] = mk(2'd0, 1'b0, 8'h00, 16'h0000, 8'd1,   -1, 0, 0, 0, 0, 16'h0000);
    vecs[15] = mk(2'd1, 1'b0, 8'h7F, 16'h0000, 8'd3,    1, 1, 0, 1, 0, 16'h0000);
    vecs[16] = mk(2'd3, 1'b0, 8'h10, 16'h0000, 8'd0,   -1, 0, 0, 0, 0, 16'h0000);
    vecs[17] = mk(2'd1, 1'b1, 8'h20, 16'h4321, 8'd0,    0, 0, 0, 0, 0, 16'h0000);
    vecs[18] = mk(2'd1, 1'b0, 8'h20, 16'h0000, 8'd1,   -1, 0, 1, 1, 0, 16'h7777);

    @(posedge clk); #1;
    @(negedge clk);
    chk("reset_ready", 32'(bus_if.ready), 32'd0);
    chk("reset_slverr", 32'(bus_if.slverr), 32'd0);
    chk("reset_wren", 32'(mem_wren), 32'd0);
    chk("reset_rden", 32'(mem_rden), 32'd0);
    chk("reset_rdata", 32'(bus_if.rdata), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // reset mid-transfer: write with W=5, two access cycles leave cnt=3
    bus_if.sel = 2'd1; bus_if.write = 1'b1; bus_if.addr = 8'h30;
    bus_if.wdata = 16'h9999; bus_if.wait_cycles = 8'd5;
    @(posedge clk); #1;
    bus_if.enable = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("midrst_ready", 32'(bus_if.ready), 32'd0);
      chk("midrst_wren", 32'(mem_wren), 32'd0);
      chk("midrst_slverr", 32'(bus_if.slverr), 32'd0);
      @(posedge clk); #1;
    end
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("postrst_ready", 32'(bus_if.ready), 32'd0);
      chk("postrst_wren", 32'(mem_wren), 32'd0);
      @(posedge clk); #1;
    end

    foreach (vecs[i]) run_vec(vecs[i]);

    bus_if.sel = '0;
    bus_if.enable = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_drain", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
